// File: rtl/uc_eng_port.sv
// ---------------------------------------------------------------------------
// uc_eng_port
//
// Per-engine endpoint of the unit-clause (UC) arbiter interface. One instance
// sits beside each BCP engine.
//
//   Inbound path : UCs broadcast by the arbiter are buffered in a show-ahead
//                  FIFO and handed to the engine core.
//   Outbound path: implied UCs produced by the core are buffered and offered
//                  to the arbiter, drained either one entry per rising edge of
//                  this engine's engmask bit (mask mode) or on a wrapper
//                  priority-queue grant (PQ mode).
//   Conflict     : an arbiter conflict flushes both FIFOs and parks the port in
//                  HALT until restart is seen with conflict low.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   uca2eng, uca2eng_push          broadcast UC from the arbiter
//   eng2uca_full                   inbound FIFO full (arbiter back-pressure)
//   core_uc, core_uc_valid         inbound head towards the core
//   core_pop                       core consumes core_uc
//   imp_uc, imp_valid, imp_ready   implied UC from the core
//   engmask, input_mode, pq_grant  outbound drain control
//   eng2uca, eng2uca_valid         outbound head / offered-this-cycle
//   eng2uca_empty                  outbound FIFO empty (or port halted)
//   conflict, restart              halt / resume control
//   overflow                       sticky: a broadcast UC was dropped
// ---------------------------------------------------------------------------
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

module uc_eng_port #(
    parameter int ENG_ID    = 0,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int LIT_W     = $clog2(`LIT_IDX_MAX) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LIT_W-1:0]       uca2eng,
    input  logic                   uca2eng_push,
    output logic                   eng2uca_full,
    output logic [LIT_W-1:0]       core_uc,
    output logic                   core_uc_valid,
    input  logic                   core_pop,
    input  logic [LIT_W-1:0]       imp_uc,
    input  logic                   imp_valid,
    output logic                   imp_ready,
    input  logic [`NUM_ENGINE-1:0] engmask,
    input  logic                   input_mode,
    input  logic                   pq_grant,
    output logic [LIT_W-1:0]       eng2uca,
    output logic                   eng2uca_valid,
    output logic                   eng2uca_empty,
    input  logic                   conflict,
    input  logic                   restart,
    output logic                   overflow
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = OUT_AW + 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q;

    // Inbound FIFO
    logic [LIT_W-1:0] in_mem [IN_DEPTH];
    logic [IN_AW-1:0] in_wr_ptr, in_rd_ptr;
    logic [IN_CW-1:0] in_count;

    // Outbound FIFO
    logic [LIT_W-1:0]  out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr, out_rd_ptr;
    logic [OUT_CW-1:0] out_count;

    // Previous value of this engine's engmask bit, for edge detection.
    logic mask_q;

    logic run;
    logic in_empty, in_full, in_push, in_rd, in_wr, in_drop;
    logic out_empty, out_full, out_wr, out_rd, grant_edge;

    // Only this engine's bit of engmask matters here.
    logic unused_engmask;
    assign unused_engmask = ^engmask;

    assign run = (state_q == RUN);

    // ---------------- inbound ----------------
    assign in_empty = (in_count == '0);
    assign in_full  = (in_count == IN_CW'(IN_DEPTH));

    assign core_uc_valid = run && !in_empty;
    assign core_uc       = in_empty ? '0 : in_mem[in_rd_ptr];
    assign eng2uca_full  = run && in_full;

    // conflict wins over every same-cycle push/pop, so a push on the conflict
    // cycle is neither stored nor counted as an overflow.
    assign in_rd   = core_pop && core_uc_valid && !conflict;
    assign in_push = uca2eng_push && run && !conflict;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign in_wr   = in_push && (!in_full || in_rd);
    assign in_drop = in_push && in_full && !in_rd;

    // ---------------- outbound ----------------
    assign out_empty = (out_count == '0);
    assign out_full  = (out_count == OUT_CW'(OUT_DEPTH));

    // No pop look-ahead: a full FIFO refuses writes even while draining.
    assign imp_ready = run && !out_full;
    assign out_wr    = imp_valid && imp_ready && !conflict;

    assign grant_edge    = engmask[ENG_ID] && !mask_q;
    assign eng2uca_valid = run && !out_empty && (input_mode ? 1'b1 : grant_edge);
    assign out_rd        = eng2uca_valid && (input_mode ? pq_grant : 1'b1) && !conflict;
    assign eng2uca       = out_empty ? '0 : out_mem[out_rd_ptr];
    assign eng2uca_empty = !run || out_empty;

    // NOTE: storage arrays carry no reset; validity comes from the reset
    // counters, and the heads are forced to zero while their FIFO is empty.
    always_ff @(posedge clk) begin
        if (in_wr) begin
            in_mem[in_wr_ptr] <= uca2eng;
        end
        if (out_wr) begin
            out_mem[out_wr_ptr] <= imp_uc;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            overflow   <= 1'b0;
            mask_q     <= 1'b0;
        end else begin
            // Edge register tracks engmask in both modes and in HALT, so a
            // bit already high when mask mode is entered is not an edge.
            mask_q <= engmask[ENG_ID];

            if (conflict) begin
                state_q    <= HALT;
                in_wr_ptr  <= '0;
                in_rd_ptr  <= '0;
                in_count   <= '0;
                out_wr_ptr <= '0;
                out_rd_ptr <= '0;
                out_count  <= '0;
            end else begin
                if (state_q == HALT && restart) begin
                    state_q <= RUN;
                end

                if (in_wr) begin
                    in_wr_ptr <= in_wr_ptr + IN_AW'(1);
                end
                if (in_rd) begin
                    in_rd_ptr <= in_rd_ptr + IN_AW'(1);
                end
                in_count <= in_count + IN_CW'(in_wr) - IN_CW'(in_rd);

                if (in_drop) begin
                    overflow <= 1'b1;
                end

                if (out_wr) begin
                    out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
                end
                if (out_rd) begin
                    out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
                end
                out_count <= out_count + OUT_CW'(out_wr) - OUT_CW'(out_rd);
            end
        end
    end

endmodule

// File: tb/tb_uc_eng_port.sv
// ---------------------------------------------------------------------------
// tb_uc_eng_port
//
// Self-checking bench for uc_eng_port. Inputs are driven on the falling edge,
// outputs are compared shortly after, before the next rising edge. A queue
// model of both FIFOs predicts every output each cycle; table vectors and
// hand-written sequences add explicit expectations for the corner cases.
// ---------------------------------------------------------------------------
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

module tb_uc_eng_port;

    localparam int NE     = `NUM_ENGINE;
    localparam int ENG_ID = 1;
    localparam int DEPTH  = 8;
    localparam int LIT_W  = $clog2(`LIT_IDX_MAX) + 1;
    localparam int MAG_W  = LIT_W - 1;

    typedef logic [LIT_W-1:0] lit_t;

    logic          clk;
    logic          rst;
    lit_t          uca2eng;
    logic          uca2eng_push;
    logic          eng2uca_full;
    lit_t          core_uc;
    logic          core_uc_valid;
    logic          core_pop;
    lit_t          imp_uc;
    logic          imp_valid;
    logic          imp_ready;
    logic [NE-1:0] engmask;
    logic          input_mode;
    logic          pq_grant;
    lit_t          eng2uca;
    logic          eng2uca_valid;
    logic          eng2uca_empty;
    logic          conflict;
    logic          restart;
    logic          overflow;

    uc_eng_port #(
        .ENG_ID   (ENG_ID),
        .IN_DEPTH (DEPTH),
        .OUT_DEPTH(DEPTH),
        .LIT_W    (LIT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uca2eng      (uca2eng),
        .uca2eng_push (uca2eng_push),
        .eng2uca_full (eng2uca_full),
        .core_uc      (core_uc),
        .core_uc_valid(core_uc_valid),
        .core_pop     (core_pop),
        .imp_uc       (imp_uc),
        .imp_valid    (imp_valid),
        .imp_ready    (imp_ready),
        .engmask      (engmask),
        .input_mode   (input_mode),
        .pq_grant     (pq_grant),
        .eng2uca      (eng2uca),
        .eng2uca_valid(eng2uca_valid),
        .eng2uca_empty(eng2uca_empty),
        .conflict     (conflict),
        .restart      (restart),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: queues hold the expected FIFO contents in order.
    lit_t in_q[$];
    lit_t out_q[$];
    bit   run_m;
    bit   ovf_m;
    bit   mask_q_m;

    // Sign-magnitude literal: MSB set means negative.
    function automatic lit_t lit(input int v);
        if (v < 0) return {1'b1, MAG_W'(-v)};
        return {1'b0, MAG_W'(v)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the inputs currently driven: compare every output
    // with the model, advance the model, then clear the single-cycle inputs.
    task automatic step();
        bit   exp_cv, exp_full, exp_ir, exp_ev, exp_empty, ge, out_pop;
        lit_t exp_cu, exp_eu;
        #1;
        exp_cv    = run_m && (in_q.size() > 0);
        exp_cu    = (in_q.size() > 0) ? in_q[0] : '0;
        exp_full  = run_m && (in_q.size() == DEPTH);
        exp_ir    = run_m && (out_q.size() < DEPTH);
        ge        = engmask[ENG_ID] && !mask_q_m;
        exp_ev    = run_m && (out_q.size() > 0) && (input_mode || ge);
        exp_eu    = (out_q.size() > 0) ? out_q[0] : '0;
        exp_empty = !run_m || (out_q.size() == 0);

        check("core_uc_valid", core_uc_valid, exp_cv);
        check("core_uc", core_uc, exp_cu);
        check("eng2uca_full", eng2uca_full, exp_full);
        check("imp_ready", imp_ready, exp_ir);
        check("eng2uca_valid", eng2uca_valid, exp_ev);
        check("eng2uca", eng2uca, exp_eu);
        check("eng2uca_empty", eng2uca_empty, exp_empty);
        check("overflow", overflow, ovf_m);

        if (conflict) begin
            run_m = 1'b0;
            in_q.delete();
            out_q.delete();
        end else if (run_m) begin
            if (core_pop && exp_cv) void'(in_q.pop_front());
            if (uca2eng_push) begin
                if (in_q.size() < DEPTH) in_q.push_back(uca2eng);
                else ovf_m = 1'b1;
            end
            out_pop = exp_ev && (input_mode ? pq_grant : 1'b1);
            if (out_pop) void'(out_q.pop_front());
            if (imp_valid && exp_ir) out_q.push_back(imp_uc);
        end else if (restart) begin
            run_m = 1'b1;
        end
        mask_q_m = engmask[ENG_ID];

        @(posedge clk);
        @(negedge clk);
        uca2eng_push = 1'b0;
        core_pop     = 1'b0;
        imp_valid    = 1'b0;
        pq_grant     = 1'b0;
        conflict     = 1'b0;
        restart      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_core_uc_valid", core_uc_valid, 1'b0);
        check("rst_core_uc", core_uc, '0);
        check("rst_imp_ready", imp_ready, 1'b1);
        check("rst_eng2uca_valid", eng2uca_valid, 1'b0);
        check("rst_eng2uca_empty", eng2uca_empty, 1'b1);
        check("rst_eng2uca_full", eng2uca_full, 1'b0);
        check("rst_eng2uca", eng2uca, '0);
        check("rst_overflow", overflow, 1'b0);
        in_q.delete();
        out_q.delete();
        run_m    = 1'b1;
        ovf_m    = 1'b0;
        mask_q_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit push;
        int val;
        bit pop;
        bit exp_valid;
        int exp_uc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        uca2eng      = '0;
        uca2eng_push = 1'b0;
        core_pop     = 1'b0;
        imp_uc       = '0;
        imp_valid    = 1'b0;
        engmask      = '0;
        input_mode   = 1'b0;
        pq_grant     = 1'b0;
        conflict     = 1'b0;
        restart      = 1'b0;

        // Inbound ordering and show-ahead latency.
        tbl[0] = '{1'b1,  5, 1'b0, 1'b0,  0};
        tbl[1] = '{1'b1, -7, 1'b0, 1'b1,  5};
        tbl[2] = '{1'b1,  2, 1'b0, 1'b1,  5};
        tbl[3] = '{1'b0,  0, 1'b1, 1'b1,  5};
        tbl[4] = '{1'b0,  0, 1'b1, 1'b1, -7};
        tbl[5] = '{1'b0,  0, 1'b1, 1'b1,  2};
        tbl[6] = '{1'b0,  0, 1'b0, 1'b0,  0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            uca2eng_push = tbl[i].push;
            uca2eng      = lit(tbl[i].val);
            core_pop     = tbl[i].pop;
            #1;
            check("tbl_valid", core_uc_valid, tbl[i].exp_valid);
            check("tbl_uc", core_uc, lit(tbl[i].exp_uc));
            step();
        end

        // Inbound fill past capacity, then push+pop while full.
        for (int i = 0; i < 9; i++) begin
            uca2eng_push = 1'b1;
            uca2eng      = lit(10 + i);
            step();
        end
        #1;
        check("full_after_8", eng2uca_full, 1'b1);
        check("ovf_after_9", overflow, 1'b1);
        uca2eng_push = 1'b1;
        uca2eng      = lit(-99);
        core_pop     = 1'b1;
        step();
        #1;
        check("full_after_pushpop", eng2uca_full, 1'b1);
        check("ovf_sticky", overflow, 1'b1);
        check("head_after_pushpop", core_uc, lit(11));
        for (int i = 0; i < 8; i++) begin
            core_pop = 1'b1;
            step();
        end
        #1;
        check("in_drained", core_uc_valid, 1'b0);

        // Mask mode: one pop per rising edge of engmask[ENG_ID].
        input_mode = 1'b0;
        engmask    = '0;
        imp_valid  = 1'b1;
        imp_uc     = lit(-3);
        step();
        imp_valid  = 1'b1;
        imp_uc     = lit(4);
        step();
        engmask = NE'(1) << ENG_ID;
        #1;
        check("mask_edge1_valid", eng2uca_valid, 1'b1);
        check("mask_edge1_data", eng2uca, lit(-3));
        step();
        #1;
        check("mask_held_valid", eng2uca_valid, 1'b0);
        check("mask_held_head", eng2uca, lit(4));
        step();
        engmask = ~(NE'(1) << ENG_ID);
        #1;
        check("mask_other_bits", eng2uca_valid, 1'b0);
        step();
        engmask = NE'(1) << ENG_ID;
        #1;
        check("mask_edge2_valid", eng2uca_valid, 1'b1);
        check("mask_edge2_data", eng2uca, lit(4));
        step();
        engmask = '0;
        step();
        engmask = NE'(1) << ENG_ID;
        #1;
        check("mask_edge_empty_valid", eng2uca_valid, 1'b0);
        check("mask_edge_empty_flag", eng2uca_empty, 1'b1);
        step();
        engmask = '0;

        // PQ mode: grant every cycle with a same-cycle write.
        input_mode = 1'b1;
        imp_valid  = 1'b1;
        imp_uc     = lit(9);
        step();
        pq_grant  = 1'b1;
        imp_valid = 1'b1;
        imp_uc    = lit(1);
        #1;
        check("pq_first_valid", eng2uca_valid, 1'b1);
        check("pq_first_data", eng2uca, lit(9));
        step();
        pq_grant = 1'b1;
        #1;
        check("pq_second_valid", eng2uca_valid, 1'b1);
        check("pq_second_data", eng2uca, lit(1));
        step();
        pq_grant = 1'b1;
        #1;
        check("pq_drained_valid", eng2uca_valid, 1'b0);
        check("pq_drained_empty", eng2uca_empty, 1'b1);
        step();

        // Outbound full: no write, no pop look-ahead on imp_ready.
        for (int i = 0; i < 8; i++) begin
            imp_valid = 1'b1;
            imp_uc    = lit(20 + i);
            step();
        end
        imp_valid = 1'b1;
        imp_uc    = lit(-50);
        #1;
        check("out_full_ready", imp_ready, 1'b0);
        step();
        pq_grant = 1'b1;
        #1;
        check("out_full_pop_ready", imp_ready, 1'b0);
        check("out_full_pop_data", eng2uca, lit(20));
        step();
        #1;
        check("out_ready_after_pop", imp_ready, 1'b1);
        step();
        for (int i = 0; i < 7; i++) begin
            pq_grant = 1'b1;
            step();
        end
        #1;
        check("out_drained", eng2uca_empty, 1'b1);

        // Reset mid-operation discards everything.
        uca2eng_push = 1'b1;
        uca2eng      = lit(1);
        imp_valid    = 1'b1;
        imp_uc       = lit(3);
        step();
        do_reset();
        step();

        // Conflict with both FIFOs populated, then HALT behaviour and restart.
        input_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            uca2eng_push = 1'b1;
            uca2eng      = lit(6 + i);
            imp_valid    = 1'b1;
            imp_uc       = lit(-(7 + i));
            step();
        end
        conflict     = 1'b1;
        uca2eng_push = 1'b1;
        uca2eng      = lit(40);
        core_pop     = 1'b1;
        step();
        #1;
        check("halt_empty", eng2uca_empty, 1'b1);
        check("halt_core_valid", core_uc_valid, 1'b0);
        check("halt_imp_ready", imp_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            uca2eng_push = 1'b1;
            uca2eng      = lit(30 + i);
            imp_valid    = 1'b1;
            imp_uc       = lit(i);
            step();
        end
        #1;
        check("halt_no_overflow", overflow, 1'b0);
        check("halt_full_low", eng2uca_full, 1'b0);
        restart  = 1'b1;
        conflict = 1'b1;
        step();
        #1;
        check("restart_blocked", imp_ready, 1'b0);
        restart = 1'b1;
        step();
        #1;
        check("run_imp_ready", imp_ready, 1'b1);
        check("run_in_empty", core_uc_valid, 1'b0);
        check("run_out_empty", eng2uca_empty, 1'b1);
        uca2eng_push = 1'b1;
        uca2eng      = lit(8);
        step();
        #1;
        check("run_push_valid", core_uc_valid, 1'b1);
        check("run_push_data", core_uc, lit(8));
        core_pop = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uc_eng_port.md
Name: uc_eng_port

Overview:
- Per-engine endpoint of the unit-clause (UC) arbiter interface. One instance sits beside each BCP engine.
- Inbound: buffers UCs broadcast by the arbiter (uca2eng/uca2eng_push) and delivers them to the engine core.
- Outbound: buffers implied UCs produced by the core and presents them to the arbiter. Draining follows either mask mode (one entry per engmask grant) or PQ mode (wrapper priority-queue grant).
- On an arbiter conflict, the port flushes both queues and halts until restarted.

Parameters:
- ENG_ID, 0, index of this engine's bit in engmask (0..`NUM_ENGINE-1)
- IN_DEPTH, 8, inbound FIFO entries (power of 2, >=2)
- OUT_DEPTH, 8, outbound FIFO entries (power of 2, >=2)
- LIT_W, $clog2(`LIT_IDX_MAX)+1, signed literal width (MSB = polarity, 1 = negative)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- uca2eng  in  LIT_W  signed broadcast UC from arbiter
- uca2eng_push  in  1  broadcast UC valid
- eng2uca_full  out  1  inbound FIFO full (this engine's bit of the arbiter's full vector)
- core_uc  out  LIT_W  inbound FIFO head
- core_uc_valid  out  1  inbound FIFO not empty and state RUN
- core_pop  in  1  core consumes core_uc
- imp_uc  in  LIT_W  implied UC from core
- imp_valid  in  1  implied UC valid
- imp_ready  out  1  outbound FIFO can accept
- engmask  in  `NUM_ENGINE  arbiter one-hot engine select
- input_mode  in  1  0 = mask mode, 1 = PQ mode
- pq_grant  in  1  wrapper PQ selects this engine (PQ mode only)
- eng2uca  out  LIT_W  outbound FIFO head
- eng2uca_valid  out  1  outbound entry offered/consumed this cycle
- eng2uca_empty  out  1  outbound FIFO empty, or state HALT
- conflict  in  1  arbiter conflict indication
- restart  in  1  leave HALT
- overflow  out  1  sticky: a broadcast UC was dropped

Behaviour:
- Reset (rst=0, async) puts the block in the following state:
  - state=RUN; both FIFOs empty; overflow=0; mask-edge register=0.
  - core_uc_valid=0, imp_ready=1, eng2uca_valid=0, eng2uca_empty=1, eng2uca_full=0.
  - core_uc and eng2uca are 0.
- Reset mid-operation discards all contents immediately.

- State machine: RUN, HALT.
  - RUN->HALT when conflict=1.
  - HALT->RUN when restart=1 and conflict=0.
  - Entering HALT clears both FIFOs on that clock edge.
  - In HALT: uca2eng_push is dropped without setting overflow; core_uc_valid=0, imp_ready=0, eng2uca_valid=0, eng2uca_empty=1, eng2uca_full=0.

- Inbound FIFO:
  - Write when uca2eng_push=1 in RUN.
  - Read when core_pop && core_uc_valid.
  - core_uc is the combinational head: zero-latency show-ahead; a pushed entry is visible the next cycle.
  - eng2uca_full = (count==IN_DEPTH), registered count.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: dropped, overflow<=1 (sticky until reset).
  - core_pop while empty: ignored.

- Outbound FIFO:
  - Write when imp_valid && imp_ready.
  - imp_ready = RUN && count<OUT_DEPTH, with no pop look-ahead.
  - Entries are stored verbatim, including the polarity bit.

- Drain, mask mode (input_mode=0):
  - grant_edge = engmask[ENG_ID] && !engmask_q[ENG_ID], where engmask_q is engmask registered each cycle.
  - Pop exactly one entry on grant_edge when not empty.
  - eng2uca_valid = grant_edge && !empty.
  - A bit held high for several cycles yields one pop.
  - An edge while empty yields no pop; eng2uca_empty=1 is shown for that cycle.
- Drain, PQ mode (input_mode=1):
  - eng2uca_valid = !empty && RUN, used as the request.
  - Pop when pq_grant && eng2uca_valid.
  - pq_grant while empty: ignored.
- eng2uca is the combinational head in both modes.
- A write to and a pop from the outbound FIFO in the same cycle are both performed, and the count is unchanged.
- Mode switch takes effect in the same cycle; engmask_q keeps updating in both modes.

- Pointers: log2(depth) bits with wrap; count is log2(depth)+1 bits.
- conflict has priority over every same-cycle push, write or pop.

Test Plan:
- Reset, then 3 pushes of +5, -7, +2 with core_pop held 0 -> core_uc=+5 valid next cycle. Then pop 3 times -> +5, -7, +2 in order, core_uc_valid drops after the third.
- 9 pushes with IN_DEPTH=8 and no pops -> eng2uca_full=1 after the 8th, 9th dropped, overflow=1. Then a push+pop at full -> accepted, count stays 8, overflow remains 1.
- Mask mode: outbound holds -3, +4; engmask[ENG_ID] high for 2 cycles, low, high again -> -3 popped on the first edge only, +4 on the second edge, eng2uca_empty=1 afterwards.
- PQ mode: outbound holds +9, pq_grant=1 every cycle, imp_valid writes +1 in the same cycle -> +9 then +1 delivered on consecutive cycles with eng2uca_valid=1.
- Outbound full (8 entries), imp_valid=1 -> imp_ready=0, no write. Then one pq_grant pop -> imp_ready=1 the next cycle.
- conflict pulse with both FIFOs non-empty -> next cycle HALT, eng2uca_empty=1, core_uc_valid=0, pushes ignored with overflow unchanged. Then restart=1 -> RUN with empty FIFOs.
